// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel glitch-free clock divider with run-time reconfig.
// Define CLKDIV_GEN_STROBE_EN to add a per-channel rising-edge strobe output.
module clk_div_gen #(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 8,
    parameter int DEF_DIV    = 4,
    parameter int DEF_DUTY   = 2,
    parameter int LOCK_WRAPS = 4
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clkout,
`ifdef CLKDIV_GEN_STROBE_EN
    output logic [NUM_CH-1:0] strobe,
`endif
    output logic              locked
);
    localparam int WC_W = $clog2(LOCK_WRAPS + 1);
    localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TWO     = CNT_W'(2);
    localparam logic [WC_W-1:0]   WC_LAST = WC_W'(LOCK_WRAPS - 1);
    localparam logic [NUM_CH-1:0] OUT_RST = {NUM_CH{1'(DEF_DUTY > 0)}};

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_SETTLE} state_t;

    state_t           state;
    logic [WC_W-1:0]  wrap_cnt;
    logic [2:0]       pend_ch;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_duty;
    logic [CNT_W-1:0] pend_phase;
    logic [CNT_W-1:0] pend_eff;
    logic [CNT_W-1:0] pend_load;

    logic [CNT_W-1:0] cnt      [NUM_CH];
    logic [CNT_W-1:0] div_q    [NUM_CH];
    logic [CNT_W-1:0] duty_q   [NUM_CH];
    logic [CNT_W-1:0] div_eff  [NUM_CH];
    logic [CNT_W-1:0] cnt_nxt  [NUM_CH];
    logic [CNT_W-1:0] div_nxt  [NUM_CH];
    logic [CNT_W-1:0] duty_nxt [NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] out_nxt;

    logic xfer;
    logic ch_ok;

    assign xfer  = cfg_valid && cfg_ready;
    assign ch_ok = ({1'b0, cfg_ch} < 4'(NUM_CH));

    always_comb begin
        pend_eff  = (pend_div < TWO) ? TWO : pend_div;
        pend_load = (pend_phase > pend_eff - ONE) ? pend_eff - ONE : pend_phase;
        for (int i = 0; i < NUM_CH; i++) begin
            div_eff[i] = (div_q[i] < TWO) ? TWO : div_q[i];
            wrap[i]    = (cnt[i] == div_eff[i] - ONE);
            apply[i]   = (state == ST_PEND) && (pend_ch == 3'(i)) && wrap[i];
            if (apply[i]) begin
                cnt_nxt[i]  = pend_load;
                div_nxt[i]  = pend_div;
                duty_nxt[i] = pend_duty;
            end else begin
                cnt_nxt[i]  = wrap[i] ? '0 : cnt[i] + ONE;
                div_nxt[i]  = div_q[i];
                duty_nxt[i] = duty_q[i];
            end
            out_nxt[i] = (cnt_nxt[i] < duty_nxt[i]);
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= '0;
                div_q[i]  <= CNT_W'(DEF_DIV);
                duty_q[i] <= CNT_W'(DEF_DUTY);
            end
            clkout <= OUT_RST;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]    <= cnt_nxt[i];
                div_q[i]  <= div_nxt[i];
                duty_q[i] <= duty_nxt[i];
            end
            clkout <= out_nxt;
        end
    end

`ifdef CLKDIV_GEN_STROBE_EN
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) strobe <= '0;
        else       strobe <= out_nxt & ~clkout;
    end
`endif

    // Post-reset start in SETTLE so lock needs LOCK_WRAPS clean ch0 periods
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state      <= ST_SETTLE;
            wrap_cnt   <= '0;
            cfg_ready  <= 1'b1;
            locked     <= 1'b0;
            pend_ch    <= '0;
            pend_div   <= '0;
            pend_duty  <= '0;
            pend_phase <= '0;
        end else begin
            case (state)
                ST_PEND: begin
                    if (|apply) begin
                        state     <= ST_SETTLE;
                        wrap_cnt  <= '0;
                        cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    if (xfer) begin
                        pend_ch    <= cfg_ch;
                        pend_div   <= cfg_div;
                        pend_duty  <= cfg_duty;
                        pend_phase <= cfg_phase;
                        wrap_cnt   <= '0;
                        locked     <= 1'b0;
                        if (ch_ok) begin
                            state     <= ST_PEND;
                            cfg_ready <= 1'b0;
                        end else begin
                            state <= ST_SETTLE;
                        end
                    end else if (state == ST_SETTLE && wrap[0]) begin
                        if (wrap_cnt == WC_LAST) begin
                            state  <= ST_IDLE;
                            locked <= 1'b1;
                        end else begin
                            wrap_cnt <= wrap_cnt + WC_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: scoreboard bench for clk_div_gen against a period-based model.
// Covers defaults, reconfig, clamping, phase, stalls, bad channel, async reset.
module tb_clk_div_gen;
    localparam int NCH   = 2;
    localparam int CW    = 8;
    localparam int LOCKW = 4;
    localparam int M_IDLE = 0;
    localparam int M_PEND = 1;
    localparam int M_SET  = 2;

    logic          clkin;
    logic          reset;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_ch;
    logic [CW-1:0] cfg_div;
    logic [CW-1:0] cfg_duty;
    logic [CW-1:0] cfg_phase;
    logic [NCH-1:0] clkout;
    logic          locked;
`ifdef CLKDIV_GEN_STROBE_EN
    logic [NCH-1:0] strobe;
`endif

    clk_div_gen #(
        .NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(4), .DEF_DUTY(2), .LOCK_WRAPS(LOCKW)
    ) dut (
        .clkin(clkin),
        .reset(reset),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_duty(cfg_duty),
        .cfg_phase(cfg_phase),
        .clkout(clkout),
`ifdef CLKDIV_GEN_STROBE_EN
        .strobe(strobe),
`endif
        .locked(locked)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    typedef struct {
        bit [NCH-1:0] out;
        bit           rdy;
        bit           lk;
        bit [NCH-1:0] stb;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Behavioural model: position within each channel's period
    int pos   [NCH];
    int mdiv  [NCH];
    int mduty [NCH];
    int mst, mw, pch, pdiv, pduty, pph;
    bit mrdy, mlk;
    bit [NCH-1:0] mout, mstb;

    function automatic int deff(int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            pos[i] = 0; mdiv[i] = 4; mduty[i] = 2;
        end
        mst = M_SET; mw = 0; mrdy = 1; mlk = 0;
        mout = '1; mstb = '0;
    endtask

    task automatic model_tick();
        bit [NCH-1:0] wr;
        bit [NCH-1:0] prev;
        bit applied;
        bit xfer;
        applied = 0;
        xfer = cfg_valid && mrdy;
        prev = mout;
        for (int i = 0; i < NCH; i++)
            wr[i] = ((pos[i] + 1) % deff(mdiv[i])) == 0;
        for (int i = 0; i < NCH; i++) begin
            if (mst == M_PEND && pch == i && wr[i]) begin
                mdiv[i] = pdiv; mduty[i] = pduty;
                pos[i] = (pph < deff(pdiv)) ? pph : deff(pdiv) - 1;
                applied = 1;
            end else begin
                pos[i] = (pos[i] + 1) % deff(mdiv[i]);
            end
            mout[i] = pos[i] < mduty[i];
        end
        mstb = mout & ~prev;
        if (mst == M_PEND) begin
            if (applied) begin mst = M_SET; mw = 0; mrdy = 1; end
        end else if (xfer) begin
            pch = int'(cfg_ch); pdiv = int'(cfg_div);
            pduty = int'(cfg_duty); pph = int'(cfg_phase);
            mw = 0; mlk = 0;
            if (pch < NCH) begin mst = M_PEND; mrdy = 0; end
            else mst = M_SET;
        end else if (mst == M_SET && wr[0]) begin
            mw++;
            if (mw == LOCKW) begin mst = M_IDLE; mlk = 1; end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.out = mout; e.rdy = mrdy; e.lk = mlk; e.stb = mstb;
        exp_q.push_back(e);
    endtask

    task automatic step();
        if (reset) model_reset();
        else model_tick();
        push_exp();
        @(posedge clkin);
        #1;
        cyc++;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic send(int ch, int dv, int dt, int ph);
        cfg_ch = 3'(ch); cfg_div = CW'(dv); cfg_duty = CW'(dt); cfg_phase = CW'(ph);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset(int hold);
        reset = 1'b1;
        #1;
        chk("rst_clkout", int'(clkout), 3);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_locked", int'(locked), 0);
`ifdef CLKDIV_GEN_STROBE_EN
        chk("rst_strobe", int'(strobe), 0);
`endif
        exp_q.delete();
        model_reset();
        push_exp();
        run(hold);
        reset = 1'b0;
    endtask

    // Monitor: every cycle the DUT presents outputs; pop and compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clkin);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("clkout", int'(clkout), int'(e.out));
                chk("cfg_ready", int'(cfg_ready), int'(e.rdy));
                chk("locked", int'(locked), int'(e.lk));
`ifdef CLKDIV_GEN_STROBE_EN
                chk("strobe", int'(strobe), int'(e.stb));
`endif
            end
        end
    end

    initial begin
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch = '0; cfg_div = '0; cfg_duty = '0; cfg_phase = '0;
        model_reset();
        #1;
        chk("init_clkout", int'(clkout), 3);
        chk("init_ready", int'(cfg_ready), 1);
        chk("init_locked", int'(locked), 0);
        run(2);
        reset = 1'b0;

        run(15);
        chk("lock_pre16", int'(locked), 0);
        step();
        chk("lock_at16", int'(locked), 1);
        run(24);

        step();
        send(1, 6, 3, 0);
        chk("ready_drop", int'(cfg_ready), 0);
        chk("lock_drop", int'(locked), 0);
        run(40);

        send(0, 1, 1, 0);
        run(30);
        send(0, 5, 0, 0);
        run(30);

        send(1, 8, 4, 20);
        run(30);

        cfg_ch = 3'd1; cfg_div = 8'd3; cfg_duty = 8'd1; cfg_phase = 8'd2;
        cfg_valid = 1'b1;
        step();
        cfg_ch = 3'd0; cfg_div = 8'd7; cfg_duty = 8'd3;
        run(14);
        cfg_valid = 1'b0;
        run(30);
        send(5, 9, 9, 9);
        run(30);

        send(1, 7, 3, 0);
        step();
        do_reset(2);
        run(40);

        for (int k = 0; k < 400; k++) begin
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_ch    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 7))
                                                    : 3'($urandom_range(0, 1));
            cfg_div   = CW'($urandom_range(0, 10));
            cfg_duty  = CW'($urandom_range(0, 11));
            cfg_phase = CW'($urandom_range(0, 15));
            step();
        end
        cfg_valid = 1'b0;
        run(20);

        @(negedge clkin);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
